tdm_mux_8x1: RTL and testbench
==============================

// Module: tdm_mux_8x1
// PURPOSE
//  Round-robin 8-to-1 packet multiplexer. Merges eight valid/ready input
//  channels onto one output stream and tags each beat with its source index
//  (out_sel), so a downstream 1-to-8 demux can steer beats back by index.
//  A packet (beats up to and including in_last) is never interleaved.
//  Sits between the channel sources and the shared serial datapath.
// PARAMETERS
//  DW        8   data width per channel, in bits
//  NCH       8   channel count; fixed at 8 (sel width is 3). Any other value is illegal.
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   8      per-channel beat valid
//  in_data    in   8*DW   channel i data at [i*DW +: DW]
//  in_last    in   8      per-channel last beat of packet
//  in_ready   out  8      per-channel beat accepted; at most one bit high
//  out_valid  out  1      output beat valid
//  out_data   out  DW     output beat data
//  out_sel    out  3      source channel index of the output beat
//  out_last   out  1      output beat is last of packet
//  out_ready  in   1      downstream accepts the output beat
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    out_valid=0, out_data=0, out_sel=0, out_last=0, state=ARB, ptr=0.
//  - Handshakes:
//    - Input transfer on channel i: in_valid[i] & in_ready[i] at a clk edge.
//    - Output transfer: out_valid & out_ready.
//  - Output register is single entry:
//    - load_ok = !out_valid | out_ready.
//    - in_ready is combinational from state, ptr, in_valid and load_ok.
//  - Latency: an accepted beat appears on out_* the next cycle. Throughput is
//    1 beat/cycle while out_ready=1.
//  - Sources must hold in_data/in_last stable while in_valid=1 and not accepted.
//  - FSM ARB:
//    - grant = first i with in_valid[i]=1, scanning ptr, ptr+1, ... mod 8.
//    - If a grant exists and load_ok: in_ready[grant]=1, the beat is loaded,
//      and cur=grant.
//    - If the beat has in_last=1: ptr<=grant+1 mod 8 and stay in ARB.
//      Otherwise go to LOCK.
//    - If no in_valid or !load_ok: in_ready=0, and ptr/state hold.
//  - FSM LOCK:
//    - Only channel cur may transfer; other channels are ignored.
//    - in_ready[cur] = in_valid[cur] & load_ok.
//    - On a transfer with in_last=1: ptr<=cur+1 mod 8 and go to ARB.
//  - ptr wrap: 7+1 -> 0.
//  - A single-beat packet (in_last=1 on the first beat) never enters LOCK.
//  - out_* hold while out_valid & !out_ready. A new beat replaces the current
//    one in the same cycle it drains (back-to-back).
//  - out_valid drops to 0 only when the register drains and no beat loads.
//  - Reset mid-packet: state returns to ARB and the in-flight output beat is
//    discarded. The source must restart the packet.
// TESTING
//  1. Reset: rst_n=0 while clk runs -> out_valid=0, out_sel=0, in_ready=8'h00.
//     After release, with in_valid=0, these stay so.
//  2. Round-robin: in_valid=8'hFF, all in_last=1, out_ready=1, data[i]=8'hA0+i.
//     out_sel must run 0,1,...,7,0,1 on consecutive cycles, with
//     out_data=8'hA0..A7.
//  3. Packet lock: ch2 sends a 3-beat packet (last on beat 3) while ch5 valid
//     throughout. Output is sel 2,2,2 (last=1 on 3rd), then sel 5.
//     in_ready[5]=0 during the ch2 packet.
//  4. Backpressure: out_ready=0 for 4 cycles with ch3 valid. out_data/out_sel
//     hold the first beat and in_ready=0 while out_valid=1. After
//     out_ready=1, beats continue with no loss or duplication.
//  5. Wrap and skip: ptr=7, only in_valid[1]=1 -> sel=1 granted. Next
//     arbitration starts at 2.
//  6. Reset mid-packet: assert rst_n=0 on the 2nd beat of a 4-beat ch4 packet.
//     out_valid=0 immediately. After release, ch6 alone valid -> granted sel=6
//     (no stale lock).

Source files
------------

// File: rtl/tdm_mux_8x1.sv
// tdm_mux_8x1: round-robin 8-to-1 packet multiplexer.
// Merges eight valid/ready channels onto one output stream. Each output beat
// carries its source index (out_sel) so a downstream demux can steer it back.
// Beats of one packet (up to and including in_last) are never interleaved.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   per-channel beat valid
//   in_data    channel i data at [i*DW +: DW]
//   in_last    per-channel last beat of packet
//   in_ready   per-channel beat accepted (at most one bit high)
//   out_valid  output beat valid
//   out_data   output beat data
//   out_sel    source channel of the output beat
//   out_last   output beat is last of its packet
//   out_ready  downstream accepts the output beat
//
// NCH is fixed at 8 because out_sel is 3 bits wide. No other value is supported.

module tdm_mux_8x1 #(
    parameter int unsigned DW  = 8,
    parameter int unsigned NCH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*DW-1:0] in_data,
    input  logic [NCH-1:0]    in_last,
    output logic [NCH-1:0]    in_ready,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [2:0]        out_sel,
    output logic              out_last,
    input  logic              out_ready
);

    typedef enum logic {StArb, StLock} state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] cur;

    logic       load_ok;
    logic       grant_found;
    logic [2:0] grant;
    logic [2:0] sel;
    logic       xfer;

    // The output register can take a beat when it is empty or draining now.
    assign load_ok = !out_valid || out_ready;

    // Round-robin scan starting at ptr; the first valid channel wins.
    always_comb begin
        logic [2:0] idx;
        grant_found = 1'b0;
        grant       = 3'd0;
        idx         = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!grant_found && in_valid[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
            end
        end
    end

    assign sel = (state == StArb) ? grant : cur;

    always_comb begin
        in_ready = '0;
        if (state == StArb) begin
            if (grant_found && load_ok) begin
                in_ready[grant] = 1'b1;
            end
        end else begin
            in_ready[cur] = in_valid[cur] && load_ok;
        end
    end

    assign xfer = |in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StArb;
            ptr       <= 3'd0;
            cur       <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 3'd0;
            out_last  <= 1'b0;
        end else begin
            // Output register: load replaces a draining beat in the same cycle.
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[32'(sel) * DW +: DW];
                out_sel   <= sel;
                out_last  <= in_last[sel];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                StArb: begin
                    if (xfer) begin
                        cur <= grant;
                        if (in_last[grant]) begin
                            ptr <= grant + 3'd1;
                        end else begin
                            state <= StLock;
                        end
                    end
                end
                StLock: begin
                    if (xfer && in_last[cur]) begin
                        ptr   <= cur + 3'd1;
                        state <= StArb;
                    end
                end
                default: state <= StArb;
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// Self-checking bench for tdm_mux_8x1: directed scenarios followed by
// randomized packet traffic checked against a behavioural model.

module tb_tdm_mux_8x1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_valid = '0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_last = '0;
    logic [7:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    logic        out_last;
    logic        out_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    tdm_mux_8x1 #(
        .DW  (8),
        .NCH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference model: next channel to consider, locked channel (-1 = none),
    // and the contents of the single-entry output register.
    int         m_ptr;
    int         m_lock;
    bit         m_valid;
    logic [7:0] m_data;
    int         m_sel;
    bit         m_last;
    logic [7:0] exp_ready;
    logic [7:0] dut_ready;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ptr   = 0;
        m_lock  = -1;
        m_valid = 0;
        m_data  = '0;
        m_sel   = 0;
        m_last  = 0;
    endfunction

    function automatic void model_comb();
        bit load_ok;
        bit found;
        int g;
        exp_ready = '0;
        load_ok   = !m_valid || out_ready;
        found     = 0;
        g         = 0;
        if (m_lock < 0) begin
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (!found && in_valid[c]) begin
                    found = 1;
                    g     = c;
                end
            end
            if (found && load_ok) exp_ready[g] = 1'b1;
        end else if (in_valid[m_lock] && load_ok) begin
            exp_ready[m_lock] = 1'b1;
        end
    endfunction

    function automatic void model_seq();
        int acc;
        acc = -1;
        for (int i = 0; i < 8; i++) if (exp_ready[i]) acc = i;
        if (acc >= 0) begin
            m_valid = 1;
            m_data  = in_data[acc*8 +: 8];
            m_sel   = acc;
            m_last  = in_last[acc];
            if (in_last[acc]) begin
                m_ptr  = (acc + 1) % 8;
                m_lock = -1;
            end else begin
                m_lock = acc;
            end
        end else if (out_ready) begin
            m_valid = 0;
        end
    endfunction

    // One clock cycle: drive inputs, check in_ready, clock, check outputs.
    task automatic cycle(input logic [7:0] v, input logic [63:0] d, input logic [7:0] l,
                         input logic ordy);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        #1;
        model_comb();
        dut_ready = in_ready;
        chk("in_ready", in_ready, exp_ready);
        @(posedge clk);
        model_seq();
        #1;
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_sel", out_sel, m_sel);
            chk("out_last", out_last, m_last);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(8'h00, 64'h0, 8'h00, 1'b1);
    endtask

    logic [63:0] d;
    logic [7:0]  l;
    int          beat;
    int          rem[8];
    bit          sv[8];
    logic [7:0]  sd[8];
    bit          sl[8];

    initial begin
        // 1. Reset
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("post_rst_sel", out_sel, 0);

        // 2. Round-robin over all channels, single-beat packets
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'hA0 + 8'(i);
        for (int k = 0; k < 10; k++) begin
            cycle(8'hFF, d, 8'hFF, 1'b1);
            chk("rr_sel", out_sel, k % 8);
            chk("rr_data", out_data, 8'hA0 + 8'(k % 8));
        end
        idle(1);

        // 3. Packet lock: ch2 three-beat packet while ch5 waits
        d = '0;
        d[5*8 +: 8] = 8'hC5;
        for (int b = 0; b < 3; b++) begin
            d[2*8 +: 8] = 8'hB0 + 8'(b);
            l = (b == 2) ? 8'h24 : 8'h20;
            cycle(8'h24, d, l, 1'b1);
            chk("lock_sel", out_sel, 2);
            chk("lock_last", out_last, (b == 2));
            chk("lock_rdy5", dut_ready[5], 0);
        end
        cycle(8'h20, d, 8'h20, 1'b1);
        chk("lock_next_sel", out_sel, 5);
        chk("lock_next_data", out_data, 8'hC5);
        idle(1);

        // 4. Backpressure on ch3
        beat = 0;
        for (int c = 0; c < 9; c++) begin
            d = '0;
            d[3*8 +: 8] = 8'hD0 + 8'(beat);
            cycle(8'h08, d, 8'h08, (c >= 5));
            if (c >= 1 && c <= 4) begin
                chk("bp_hold_data", out_data, 8'hD0);
                chk("bp_hold_sel", out_sel, 3);
                chk("bp_rdy", dut_ready, 0);
            end
            if (dut_ready[3]) beat++;
        end
        chk("bp_beats", beat, 5);
        idle(2);

        // 5. Wrap and skip: move pointer to 7, then only ch1 valid
        d = '0;
        d[6*8 +: 8] = 8'h66;
        cycle(8'h40, d, 8'h40, 1'b1);
        d[1*8 +: 8] = 8'h11;
        cycle(8'h02, d, 8'h02, 1'b1);
        chk("wrap_sel", out_sel, 1);
        d[0*8 +: 8] = 8'h00;
        d[2*8 +: 8] = 8'h22;
        cycle(8'h07, d, 8'h07, 1'b1);
        chk("skip_sel", out_sel, 2);
        idle(2);

        // 6. Reset in the middle of a ch4 packet
        d = '0;
        d[4*8 +: 8] = 8'hE0;
        cycle(8'h10, d, 8'h00, 1'b1);
        d[4*8 +: 8] = 8'hE1;
        cycle(8'h10, d, 8'h00, 1'b1);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = '0;
        #1;
        model_reset();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        d = '0;
        d[6*8 +: 8] = 8'hF6;
        cycle(8'h40, d, 8'h40, 1'b1);
        chk("mid_rst_sel", out_sel, 6);
        chk("mid_rst_data", out_data, 8'hF6);
        idle(2);

        // 7. Random multi-beat traffic with random backpressure
        for (int i = 0; i < 8; i++) begin
            rem[i] = 0;
            sv[i]  = 0;
            sd[i]  = '0;
            sl[i]  = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            d = '0;
            l = '0;
            for (int i = 0; i < 8; i++) begin
                if (!sv[i] && $urandom_range(0, 2) == 0) begin
                    if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
                    sv[i] = 1;
                    sd[i] = 8'($urandom);
                    sl[i] = (rem[i] == 1);
                end
                d[i*8 +: 8] = sd[i];
                l[i]        = sl[i];
            end
            cycle({sv[7], sv[6], sv[5], sv[4], sv[3], sv[2], sv[1], sv[0]}, d, l,
                  ($urandom_range(0, 3) != 0));
            for (int i = 0; i < 8; i++) begin
                if (sv[i] && dut_ready[i]) begin
                    sv[i] = 0;
                    rem[i]--;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
